scale_mux_arbiter: RTL

SCALE_MUX_ARBITER -- requirements
Module: scale_mux_arbiter

---
 rtl/scale_mux_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/scale_mux_arbiter.sv
// scale_mux_arbiter: two-requester round-robin arbiter in front of a one-word
// output register. A grant loads the selected payload through a shared
// scale_mux. A drain and a new grant can happen in the same cycle, which
// sustains one word per cycle. Saturating grant counters are kept per requester.

module scale_mux #(
   parameter int WIDTH = 8
) (
   input  logic             sel_a,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] out_mux
);

   assign out_mux = sel_a ? in_a : in_b;

endmodule

module scale_mux_arbiter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             req_a,
   input  logic [WIDTH-1:0] data_a,
   output logic             gnt_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_b,
   output logic             gnt_b,
   output logic             sel_a,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] out_data_reg;
   logic             sel_reg;
   logic             last_a_reg;

   logic             free;
   logic             gnt_a_next;
   logic             gnt_b_next;
   logic             sel_next;
   logic [WIDTH-1:0] mux_data;
   logic [1:0]       gnt_vec;

   // The output register can take a new word when empty or draining this cycle.
   assign free = (state_reg == EMPTY) | out_ready;

   // Round-robin decision: a tie goes to whoever was not granted last.
   // Grants are forced low while reset is held.
   always_comb begin
      gnt_a_next = 1'b0;
      gnt_b_next = 1'b0;
      if (rst_ && free) begin
         if (req_a && (!req_b || !last_a_reg))
            gnt_a_next = 1'b1;
         else if (req_b)
            gnt_b_next = 1'b1;
      end
   end

   // The select follows the winner in the grant cycle, so the mux output is
   // valid at the loading edge. It holds the previous choice otherwise.
   assign sel_next = gnt_a_next ? 1'b1 : (gnt_b_next ? 1'b0 : sel_reg);

   scale_mux #(
      .WIDTH (WIDTH)
   ) u_mux (
      .sel_a   (sel_next),
      .in_a    (data_a),
      .in_b    (data_b),
      .out_mux (mux_data)
   );

   // EMPTY/FULL control for the output register, together with the select
   // and the priority pointer.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_reg    <= EMPTY;
         out_data_reg <= '0;
         sel_reg      <= 1'b1;
         last_a_reg   <= 1'b0;
      end else begin
         if (gnt_a_next || gnt_b_next) begin
            sel_reg    <= gnt_a_next;
            last_a_reg <= gnt_a_next;
         end
         case (state_reg)
            EMPTY: begin
               if (gnt_a_next || gnt_b_next) begin
                  state_reg    <= FULL;
                  out_data_reg <= mux_data;
               end
            end
            FULL: begin
               if (out_ready) begin
                  if (gnt_a_next || gnt_b_next)
                     out_data_reg <= mux_data;
                  else
                     state_reg <= EMPTY;
               end
            end
            default: state_reg <= EMPTY;
         endcase
      end
   end

   assign gnt_vec = {gnt_b_next, gnt_a_next};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi = gi + 1) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;
         // Count grants for one requester and stick at the all-ones value.
         always_ff @(posedge clk or negedge rst_) begin
            if (!rst_)
               cnt_reg <= '0;
            else if (gnt_vec[gi] && (cnt_reg != {CNT_W{1'b1}}))
               cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   endgenerate

   assign gnt_a     = gnt_a_next;
   assign gnt_b     = gnt_b_next;
   assign sel_a     = sel_next;
   assign out_valid = (state_reg == FULL);
   assign out_data  = out_data_reg;
   assign cnt_a     = g_cnt[0].cnt_reg;
   assign cnt_b     = g_cnt[1].cnt_reg;

endmodule
